// File: rtl/rf_pkg.sv
// Purpose: shared constants and the byte-lane merge helper for the register file.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
// Contents: RF_WIDTH/RF_DEPTH defaults, RF_MAX_WIDTH merge ceiling, byteMerge().
package rf_pkg;

   localparam int RF_WIDTH     = 32;
   localparam int RF_DEPTH     = 8;
   // Widest word byteMerge can handle. Callers size-cast their words up to
   // this width and cast the result back down to their own WIDTH.
   localparam int RF_MAX_WIDTH = 1024;

   // Returns oldWord with every byte lane whose enable is set replaced by the
   // matching lane of newWord.
   function automatic logic [RF_MAX_WIDTH-1:0] byteMerge(
      input logic [RF_MAX_WIDTH-1:0]   oldWord,
      input logic [RF_MAX_WIDTH-1:0]   newWord,
      input logic [RF_MAX_WIDTH/8-1:0] be
   );
      logic [RF_MAX_WIDTH-1:0] merged;
      merged = oldWord;
      for (int i = 0; i < RF_MAX_WIDTH/8; i++) begin
         if (be[i]) begin
            merged[8*i +: 8] = newWord[8*i +: 8];
         end
      end
      return merged;
   endfunction

endpackage

// File: rtl/rf_read_port.sv
// Purpose: one registered read port: address range check, write-first bypass, output flops.
// Latency: 1 cycle from rAddr sampled at an edge to rData/rValid.
// Backpressure: none; a result is produced every cycle.
// Ports: clk, reset, clear | rAddr | memData/memWritten (storage view) |
//        wHit/wAddr/wWord (same-edge write) | rData, rValid (registered outputs).
module rf_read_port
   import rf_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int DEPTH = RF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clear,
   input  logic [AW-1:0]    rAddr,
   input  logic [WIDTH-1:0] memData [DEPTH],
   input  logic [DEPTH-1:0] memWritten,
   input  logic             wHit,
   input  logic [AW-1:0]    wAddr,
   input  logic [WIDTH-1:0] wWord,
   output logic [WIDTH-1:0] rData,
   output logic             rValid
);

   // One extra bit so DEPTH itself is representable (e.g. DEPTH=256, AW=8).
   localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

   logic inRange;

   assign inRange = ({1'b0, rAddr} < DEPTH_LIM);

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         rData  <= '0;
         rValid <= 1'b0;
      end else if (!inRange) begin
         rData  <= '0;
         rValid <= 1'b0;
      end else if (wHit && (wAddr == rAddr)) begin
         // Write-first: show the merged word being stored at this same edge.
         rData  <= wWord;
         rValid <= 1'b1;
      end else begin
         rData  <= memData[rAddr];
         rValid <= memWritten[rAddr];
      end
   end

endmodule

// File: rtl/multiport_register_file.sv
// Purpose: DEPTH x WIDTH flop-based register file, one byte-masked write port, two read ports.
// Latency: 1 cycle read, write-first bypass on a same-edge address match.
// Backpressure: none; every edge accepts a write and serves both reads.
// Ports: clk, reset (sync, active-high), clear (sync bulk clear) |
//        we, wAddr, wData, wBe (write) | rAddr0/1 -> rData0/1, rValid0/1 (reads).
module multiport_register_file
   import rf_pkg::*;
#(
   parameter int WIDTH = RF_WIDTH,
   parameter int DEPTH = RF_DEPTH,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               we,
   input  logic [AW-1:0]      wAddr,
   input  logic [WIDTH-1:0]   wData,
   input  logic [WIDTH/8-1:0] wBe,
   input  logic [AW-1:0]      rAddr0,
   input  logic [AW-1:0]      rAddr1,
   output logic [WIDTH-1:0]   rData0,
   output logic [WIDTH-1:0]   rData1,
   output logic               rValid0,
   output logic               rValid1
);

   localparam logic [AW:0] DEPTH_LIM = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [DEPTH-1:0] written;

   logic             wInRange;
   logic             wHit;
   logic [WIDTH-1:0] oldWord;
   logic [WIDTH-1:0] wMerged;

   // Out-of-range write addresses are dropped entirely (no data, no flag).
   always_comb begin
      wInRange = ({1'b0, wAddr} < DEPTH_LIM);
      wHit     = we && wInRange;
      oldWord  = wInRange ? mem[wAddr] : '0;
      wMerged  = WIDTH'(byteMerge(RF_MAX_WIDTH'(oldWord),
                                  RF_MAX_WIDTH'(wData),
                                  (RF_MAX_WIDTH/8)'(wBe)));
   end

   // Reset and clear both dominate the write, so a write at that edge is lost.
   // The written flag is set even when no byte enable is active.
   always_ff @(posedge clk) begin
      if (reset || clear) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem[i] <= '0;
         end
         written <= '0;
      end else if (wHit) begin
         mem[wAddr]     <= wMerged;
         written[wAddr] <= 1'b1;
      end
   end

   rf_read_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_readPort0 (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .rAddr      (rAddr0),
      .memData    (mem),
      .memWritten (written),
      .wHit       (wHit),
      .wAddr      (wAddr),
      .wWord      (wMerged),
      .rData      (rData0),
      .rValid     (rValid0)
   );

   rf_read_port #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH),
      .AW    (AW)
   ) u_readPort1 (
      .clk        (clk),
      .reset      (reset),
      .clear      (clear),
      .rAddr      (rAddr1),
      .memData    (mem),
      .memWritten (written),
      .wHit       (wHit),
      .wAddr      (wAddr),
      .wWord      (wMerged),
      .rData      (rData1),
      .rValid     (rValid1)
   );

endmodule

// File: tb/tb_multiport_register_file.sv
// Purpose: directed scoreboard bench for multiport_register_file (DEPTH=8 and DEPTH=6 instances).
// Latency: expectations are queued at the edge and checked 1 time unit later.
// Backpressure: n/a.
module tb_multiport_register_file;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset = 1'b1;
   logic        clear = 1'b0;
   logic        we    = 1'b0;
   logic [2:0]  wAddr = '0;
   logic [31:0] wData = '0;
   logic [3:0]  wBe   = '0;
   logic [2:0]  rAddr0 = '0;
   logic [2:0]  rAddr1 = '0;

   logic [31:0] rData0A, rData1A, rData0B, rData1B;
   logic        rValid0A, rValid1A, rValid0B, rValid1B;

   multiport_register_file #(.WIDTH(32), .DEPTH(8)) dutA (
      .clk(clk), .reset(reset), .clear(clear), .we(we), .wAddr(wAddr),
      .wData(wData), .wBe(wBe), .rAddr0(rAddr0), .rAddr1(rAddr1),
      .rData0(rData0A), .rData1(rData1A), .rValid0(rValid0A), .rValid1(rValid1A)
   );

   multiport_register_file #(.WIDTH(32), .DEPTH(6)) dutB (
      .clk(clk), .reset(reset), .clear(clear), .we(we), .wAddr(wAddr),
      .wData(wData), .wBe(wBe), .rAddr0(rAddr0), .rAddr1(rAddr1),
      .rData0(rData0B), .rData1(rData1B), .rValid0(rValid0B), .rValid1(rValid1B)
   );

   typedef struct {
      bit          dut;   // 0 = DEPTH 8, 1 = DEPTH 6
      bit          c0;
      logic [31:0] d0;
      logic        v0;
      bit          c1;
      logic [31:0] d1;
      logic        v1;
      int          id;
   } exp_t;

   exp_t expQ[$];
   int   vectors     = 0;
   int   miscompares = 0;
   int   nextId      = 0;

   localparam bit A = 1'b0;
   localparam bit B = 1'b1;

   // Drive one cycle of inputs at the falling edge and return right after the rising edge.
   task automatic step(input logic rst, input logic clr, input logic w,
                       input logic [2:0] wa, input logic [31:0] wd, input logic [3:0] be,
                       input logic [2:0] ra0, input logic [2:0] ra1);
      @(negedge clk);
      reset  = rst;
      clear  = clr;
      we     = w;
      wAddr  = wa;
      wData  = wd;
      wBe    = be;
      rAddr0 = ra0;
      rAddr1 = ra1;
      @(posedge clk);
   endtask

   // Expected outputs after the edge the preceding step() just crossed.
   task automatic chkBoth(input bit dut, input logic [31:0] d0, input logic v0,
                          input logic [31:0] d1, input logic v1);
      exp_t e;
      e.dut = dut; e.c0 = 1'b1; e.d0 = d0; e.v0 = v0;
      e.c1 = 1'b1; e.d1 = d1; e.v1 = v1; e.id = nextId;
      nextId++;
      expQ.push_back(e);
   endtask

   task automatic checkPort(input int id, input bit dut, input int port,
                            input logic [31:0] ad, input logic av,
                            input logic [31:0] ed, input logic ev);
      vectors++;
      if (ad !== ed || av !== ev) begin
         miscompares++;
         $display("FAIL vec%0d dut%s port%0d: got data=%h valid=%b, want data=%h valid=%b",
                  id, dut ? "B" : "A", port, ad, av, ed, ev);
      end
   endtask

   // Monitor: sample outputs 1 unit after each rising edge.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() != 0) begin
            e = expQ.pop_front();
            if (e.c0)
               checkPort(e.id, e.dut, 0, e.dut ? rData0B : rData0A,
                         e.dut ? rValid0B : rValid0A, e.d0, e.v0);
            if (e.c1)
               checkPort(e.id, e.dut, 1, e.dut ? rData1B : rData1A,
                         e.dut ? rValid1B : rValid1A, e.d1, e.v1);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      // Reset held for two edges.
      step(1, 0, 0, 0, 32'h0, 4'h0, 0, 0); chkBoth(A, 32'h0, 0, 32'h0, 0);
      step(1, 0, 0, 0, 32'h0, 4'h0, 0, 0); chkBoth(B, 32'h0, 0, 32'h0, 0);

      // Fresh entries read as zero / not valid.
      for (int a = 0; a < 8; a++) begin
         step(0, 0, 0, 0, 32'h0, 4'h0, 3'(a), 3'(7 - a));
         chkBoth(A, 32'h0, 0, 32'h0, 0);
      end

      // Full-word writes.
      step(0, 0, 1, 0, 32'h11111111, 4'hF, 7, 7); chkBoth(A, 32'h0, 0, 32'h0, 0);
      step(0, 0, 1, 1, 32'hff00ff00, 4'hF, 7, 7);
      step(0, 0, 1, 2, 32'hff00ff00, 4'hF, 7, 7);
      step(0, 0, 1, 3, 32'h00ff00ff, 4'hF, 7, 7);
      step(0, 0, 0, 0, 32'h0, 4'h0, 1, 3); chkBoth(A, 32'hff00ff00, 1, 32'h00ff00ff, 1);
      step(0, 0, 0, 0, 32'h0, 4'h0, 0, 2); chkBoth(A, 32'h11111111, 1, 32'hff00ff00, 1);

      // Partial write to addr 2 with bypass, then plain read and hold.
      step(0, 0, 1, 2, 32'h12345678, 4'b0101, 2, 2); chkBoth(A, 32'hff34ff78, 1, 32'hff34ff78, 1);
      step(0, 0, 0, 0, 32'h0, 4'h0, 2, 2); chkBoth(A, 32'hff34ff78, 1, 32'hff34ff78, 1);
      step(0, 0, 0, 0, 32'h0, 4'h0, 2, 2); chkBoth(A, 32'hff34ff78, 1, 32'hff34ff78, 1);

      // Same-edge write-first on both ports.
      step(0, 0, 1, 5, 32'ha5a5a5a5, 4'hF, 5, 5); chkBoth(A, 32'ha5a5a5a5, 1, 32'ha5a5a5a5, 1);

      // Write with no byte enables still marks the entry written.
      step(0, 0, 1, 6, 32'hffffffff, 4'h0, 6, 4); chkBoth(A, 32'h0, 1, 32'h0, 0);
      step(0, 0, 0, 0, 32'h0, 4'h0, 6, 5); chkBoth(A, 32'h0, 1, 32'ha5a5a5a5, 1);

      // Clear beats a simultaneous write; everything reads back empty.
      step(0, 1, 1, 4, 32'hdeadbeef, 4'hF, 4, 1); chkBoth(A, 32'h0, 0, 32'h0, 0);
      for (int a = 0; a < 8; a++) begin
         step(0, 0, 0, 0, 32'h0, 4'h0, 3'(a), 3'(a));
         chkBoth(A, 32'h0, 0, 32'h0, 0);
      end

      // DEPTH=6 instance: out-of-range write/read.
      step(1, 0, 0, 0, 32'h0, 4'h0, 0, 0); chkBoth(B, 32'h0, 0, 32'h0, 0);
      step(0, 0, 1, 7, 32'h77777777, 4'hF, 7, 7); chkBoth(B, 32'h0, 0, 32'h0, 0);
      step(0, 0, 0, 0, 32'h0, 4'h0, 7, 5); chkBoth(B, 32'h0, 0, 32'h0, 0);
      step(0, 0, 1, 5, 32'h55555555, 4'hF, 5, 7); chkBoth(B, 32'h55555555, 1, 32'h0, 0);

      // Reset in the middle of a write burst.
      step(0, 0, 1, 1, 32'h11111111, 4'hF, 1, 0); chkBoth(B, 32'h11111111, 1, 32'h0, 0);
      step(1, 0, 1, 2, 32'h22222222, 4'hF, 2, 1); chkBoth(B, 32'h0, 0, 32'h0, 0);
      step(0, 0, 1, 3, 32'h33333333, 4'hF, 3, 2); chkBoth(B, 32'h33333333, 1, 32'h0, 0);
      step(0, 0, 0, 0, 32'h0, 4'h0, 1, 5); chkBoth(B, 32'h0, 0, 32'h0, 0);
      step(0, 0, 0, 0, 32'h0, 4'h0, 3, 2); chkBoth(B, 32'h33333333, 1, 32'h0, 0);

      // Let the monitor drain.
      @(negedge clk);
      @(negedge clk);
      if (expQ.size() != 0) begin
         miscompares++;
         $display("FAIL drain: %0d expectations left, want 0", expQ.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/multiport_register_file.md
MULTIPORT_REGISTER_FILE -- requirements
Module: multiport_register_file

Interface
REQ-001 Parameter WIDTH, default 32, data word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter DEPTH, default 8, number of entries; SHALL be 2..256 and need not be a power of two.
REQ-003 Parameter AW, default $clog2(DEPTH), address width.
REQ-004 clk  in  1  single clock; all state SHALL change on the rising edge only.
REQ-005 reset  in  1  reset, synchronous and active-high.
REQ-006 clear  in  1  synchronous bulk clear of all entries.
REQ-007 we  in  1  write enable.
REQ-008 wAddr  in  AW  write address.
REQ-009 wData  in  WIDTH  write data.
REQ-010 wBe  in  WIDTH/8  byte enables; bit i SHALL qualify wData[8i+7:8i].
REQ-011 rAddr0, rAddr1  in  AW  read addresses, ports 0 and 1.
REQ-012 rData0, rData1  out  WIDTH  registered read data.
REQ-013 rValid0, rValid1  out  1  registered flag: the addressed entry has been written since the last reset or clear.

Function
REQ-014 Storage SHALL be DEPTH x WIDTH data plus one written-flag per entry.
REQ-015 Write: at an edge with we=1 and wAddr<DEPTH, each byte with wBe=1 SHALL update, other bytes SHALL hold, and the written-flag SHALL be set even if wBe=0.
REQ-016 Writes with wAddr>=DEPTH SHALL be ignored.
REQ-017 Read latency SHALL be one cycle: rDataN/rValidN after edge k reflect rAddrN sampled at edge k.
REQ-018 Bypass: if at edge k we=1 and wAddr==rAddrN, rDataN SHALL present the post-write merged word and rValidN SHALL be 1 (write-first).
REQ-019 Both read ports SHALL be independent; equal addresses on both ports SHALL return identical data.
REQ-020 Reads with rAddrN>=DEPTH SHALL return rDataN=0, rValidN=0.
REQ-021 clear=1 at an edge SHALL zero all entries and written-flags, and set rData0/1=0 and rValid0/1=0 at that edge.
REQ-022 clear SHALL take priority over a simultaneous write; that write SHALL be discarded.
REQ-023 An entry never written since reset or clear SHALL read as 0 with rValid=0.
REQ-024 Outputs SHALL hold their value when the read address is unchanged and no write targets it.

Reset
REQ-025 reset=1 at an edge SHALL zero all entries, all written-flags, rData0, rData1, rValid0 and rValid1.
REQ-026 reset SHALL take priority over clear and we.
REQ-027 Reset asserted mid-sequence SHALL discard any write at that edge; the first operations honoured SHALL be at the first edge with reset=0.

Structure
REQ-028 Package rf_pkg SHALL hold the default WIDTH/DEPTH constants and a byte-merge function (old word, new word, byte enables -> merged word).
REQ-029 One sub-module rf_read_port (address range check, bypass compare, output registers) SHALL be instantiated once per read port.
REQ-030 Storage SHALL be flip-flops with no inferred RAM macro.

Verification
REQ-031 Reset held 2 cycles, then release; read address 0..7 on both ports -> rData=0, rValid=0 throughout.
REQ-032 we=1, wBe=4'hF: write 11111111 to addr 0, ff00ff00 to 1 and 2, 00ff00ff to 3; then we=0 and read 1 and 3 -> ff00ff00 and 00ff00ff one cycle later, rValid=1.
REQ-033 Addr 2 holds ff00ff00; write wData=12345678, wBe=4'b0101 -> reading addr 2 returns ff34ff78.
REQ-034 Same-edge write of a5a5a5a5 to addr 5 with rAddr0=rAddr1=5 -> both ports show a5a5a5a5, rValid=1 after that edge.
REQ-035 clear and we (addr 4, data deadbeef) asserted together -> addr 4 reads 0, rValid=0, and all other entries read 0.
REQ-036 DEPTH=6 instance: write to addr 7 is ignored; reading addr 7 -> 0 and rValid=0; reset during a write burst -> the write at the reset edge is absent afterwards.
